// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM output stage and the sample producers feeding it.
package pwm_dac_pkg;

   localparam int N_FRAC_DEFAULT = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

   // Signed two's-complement sample of the given width to offset-binary duty.
   function automatic logic [31:0] offset_binary(input logic [31:0] sample, input int unsigned width);
      return sample ^ (32'd1 << (width - 1));
   endfunction

endpackage

// File: rtl/period_counter.sv
// Free-running W-bit counter with synchronous clear/hold and a terminal-count flag.
module period_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/pwm_dac.sv
// PWM output stage: requests one sample per period, double-buffers it and drives a
// pulse whose high time equals the offset-binary duty of the current sample.
module pwm_dac
   import pwm_dac_pkg::*;
#(
   parameter int N_FRAC = N_FRAC_DEFAULT
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          enable_i,
   input  logic [N_FRAC:0] data_i,
   input  logic          data_in_valid_strobe_i,
   input  logic          underrun_clr_i,
   output logic          next_data_strobe_o,
   output logic          pwm_o,
   output logic          underrun_o
);

   localparam int W = N_FRAC + 1;

   state_e       state_q, state_d;
   logic [W-1:0] pending_q, pending_d;
   logic         pending_vld_q, pending_vld_d;
   logic [W-1:0] active_q, active_d;
   logic         underrun_q, underrun_d;
   logic [W-1:0] cnt;
   logic         wrap;
   logic         cnt_clr;
   logic [W-1:0] duty_in;

   assign duty_in = W'(offset_binary(32'(data_i), W));
   assign cnt_clr = (state_q == IDLE) || !enable_i;

   period_counter #(.W(W)) u_period_counter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (cnt_clr),
      .en_i   (1'b1),
      .cnt_o  (cnt),
      .wrap_o (wrap)
   );

   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      pending_vld_d = pending_vld_q;
      active_d      = active_q;
      underrun_d    = underrun_q;

      // A set later in this block overrides the clear.
      if (underrun_clr_i) begin
         underrun_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d = PRIME;
            end
         end
         default: begin
            if (!enable_i) begin
               state_d       = IDLE;
               pending_vld_d = 1'b0;
               active_d      = '0;
            end else if (wrap) begin
               pending_vld_d = 1'b0;
               if (data_in_valid_strobe_i) begin
                  active_d = duty_in;
                  state_d  = RUN;
               end else if (pending_vld_q) begin
                  active_d = pending_q;
                  state_d  = RUN;
               end else if (state_q == RUN) begin
                  underrun_d = 1'b1;
               end
            end else if (data_in_valid_strobe_i) begin
               pending_d     = duty_in;
               pending_vld_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q       <= IDLE;
         pending_q     <= '0;
         pending_vld_q <= 1'b0;
         active_q      <= '0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         pending_vld_q <= pending_vld_d;
         active_q      <= active_d;
         underrun_q    <= underrun_d;
      end
   end

   // Outputs decode registers only, so reset drops them without waiting for an edge.
   assign next_data_strobe_o = (state_q != IDLE) && (cnt == '0);
   assign pwm_o              = (state_q == RUN) && (cnt < active_q);
   assign underrun_o         = underrun_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: a per-period plan of producer responses is turned into expected
// waveforms (pwm, request strobe, underrun flag) for each 256-cycle period.
module tb_pwm_dac;

   localparam int P = 256;
   localparam int NP = 16;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       enable_i = 1'b0;
   logic [7:0] data_i = '0;
   logic       data_in_valid_strobe_i = 1'b0;
   logic       underrun_clr_i = 1'b0;
   logic       next_data_strobe_o;
   logic       pwm_o;
   logic       underrun_o;

   int vec_cnt;
   int err_cnt;

   // Plan: per period, up to two responses (offset/value) and an optional clear offset.
   int n_resp [NP];
   int off_a  [NP];
   int val_a  [NP];
   int off_b  [NP];
   int val_b  [NP];
   int clr_off[NP];

   // Reference model: duty in force, whether output is running, sticky flag.
   int m_duty;
   bit m_running;
   bit m_ur;

   pwm_dac #(.N_FRAC(7)) dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .enable_i               (enable_i),
      .data_i                 (data_i),
      .data_in_valid_strobe_i (data_in_valid_strobe_i),
      .underrun_clr_i         (underrun_clr_i),
      .next_data_strobe_o     (next_data_strobe_o),
      .pwm_o                  (pwm_o),
      .underrun_o             (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic clear_plan();
      for (int p = 0; p < NP; p++) begin
         n_resp[p]  = 0;
         off_a[p]   = 0;
         val_a[p]   = 0;
         off_b[p]   = 0;
         val_b[p]   = 0;
         clr_off[p] = -1;
      end
   endtask

   task automatic loopback(input int p, input int v);
      n_resp[p] = 1;
      off_a[p]  = 1;
      val_a[p]  = v;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      enable_i = 1'b0;
      data_in_valid_strobe_i = 1'b0;
      underrun_clr_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      m_duty = 0;
      m_running = 1'b0;
      m_ur = 1'b0;
   endtask

   task automatic run_plan(input int nper, input bit do_enable, input string tag);
      logic [P-1:0] exp_pwm, obs_pwm, exp_stb, obs_stb, exp_ur, obs_ur;
      bit ur_start;
      int last;
      if (do_enable) begin
         enable_i = 1'b1;
         @(posedge clk_i);
         #1;
      end
      for (int p = 0; p < nper; p++) begin
         ur_start = m_ur;
         for (int c = 0; c < P; c++) begin
            exp_pwm[c] = m_running && (c < m_duty);
            exp_stb[c] = (c == 0);
            exp_ur[c]  = (clr_off[p] >= 0 && c > clr_off[p]) ? 1'b0 : ur_start;
         end
         for (int c = 0; c < P; c++) begin
            obs_pwm[c] = pwm_o;
            obs_stb[c] = next_data_strobe_o;
            obs_ur[c]  = underrun_o;
            data_in_valid_strobe_i = 1'b0;
            data_i = 8'($urandom);
            underrun_clr_i = (c == clr_off[p]);
            if (n_resp[p] >= 1 && c == off_a[p]) begin
               data_in_valid_strobe_i = 1'b1;
               data_i = 8'(val_a[p]);
            end
            if (n_resp[p] >= 2 && c == off_b[p]) begin
               data_in_valid_strobe_i = 1'b1;
               data_i = 8'(val_b[p]);
            end
            @(posedge clk_i);
            #1;
         end
         data_in_valid_strobe_i = 1'b0;
         underrun_clr_i = 1'b0;
         last = (n_resp[p] == 2) ? val_b[p] : val_a[p];
         if (clr_off[p] >= 0) m_ur = 1'b0;
         if (n_resp[p] > 0) begin
            m_duty = last + 128;
            m_running = 1'b1;
         end else if (m_running) begin
            m_ur = 1'b1;
         end
         vec_cnt += 3;
         if (obs_pwm !== exp_pwm) begin
            err_cnt++;
            $display("FAIL %s p%0d pwm: got %h expected %h", tag, p, obs_pwm, exp_pwm);
         end
         if (obs_stb !== exp_stb) begin
            err_cnt++;
            $display("FAIL %s p%0d strobe: got %h expected %h", tag, p, obs_stb, exp_stb);
         end
         if (obs_ur !== exp_ur) begin
            err_cnt++;
            $display("FAIL %s p%0d underrun: got %h expected %h", tag, p, obs_ur, exp_ur);
         end
         $display("%s period %0d: duty_next=%0d running=%0d underrun=%0d", tag, p, m_duty, m_running, m_ur);
      end
   endtask

   task automatic test_reset();
      logic [2:0] obs;
      int stb_seen, pwm_seen;
      #2 rst_i = 1'b0;
      #1;
      obs = {pwm_o, next_data_strobe_o, underrun_o};
      vec_cnt++;
      if (obs !== 3'b000) begin
         err_cnt++;
         $display("FAIL reset_init: got %b expected 000", obs);
      end
      $display("reset_init: outputs %b", obs);
      do_reset();
      clear_plan();
      loopback(0, 0);
      loopback(2, 0);
      run_plan(3, 1'b1, "reset_prep");
      obs = {pwm_o, next_data_strobe_o, underrun_o};
      vec_cnt++;
      if (obs !== 3'b111) begin
         err_cnt++;
         $display("FAIL reset_pre: got %b expected 111", obs);
      end
      #3 rst_i = 1'b0;
      #1;
      obs = {pwm_o, next_data_strobe_o, underrun_o};
      vec_cnt++;
      if (obs !== 3'b000) begin
         err_cnt++;
         $display("FAIL reset_async: got %b expected 000", obs);
      end
      $display("reset_async: outputs %b", obs);
      @(negedge clk_i);
      rst_i = 1'b1;
      enable_i = 1'b0;
      m_duty = 0;
      m_running = 1'b0;
      m_ur = 1'b0;
      @(posedge clk_i);
      #1;
      stb_seen = 0;
      pwm_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         data_in_valid_strobe_i = 1'($urandom);
         data_i = 8'($urandom);
         @(posedge clk_i);
         #1;
         stb_seen += int'(next_data_strobe_o !== 1'b0);
         pwm_seen += int'(pwm_o !== 1'b0);
      end
      data_in_valid_strobe_i = 1'b0;
      vec_cnt++;
      if (stb_seen != 0 || pwm_seen != 0) begin
         err_cnt++;
         $display("FAIL idle_quiet: got strobes=%0d pwm=%0d expected 0/0", stb_seen, pwm_seen);
      end
      $display("idle_quiet: strobes=%0d pwm_high=%0d", stb_seen, pwm_seen);
      clear_plan();
      loopback(1, 0);
      loopback(2, 50);
      run_plan(3, 1'b1, "idle_ignore");
   endtask

   task automatic test_normal();
      do_reset();
      clear_plan();
      for (int p = 0; p < 5; p++) loopback(p, 0);
      run_plan(5, 1'b1, "normal");
   endtask

   task automatic test_extremes();
      clear_plan();
      loopback(0, -128);
      loopback(1, -128);
      loopback(2, 127);
      loopback(3, 127);
      loopback(4, 0);
      run_plan(5, 1'b0, "extremes");
   endtask

   task automatic test_underrun();
      clear_plan();
      loopback(0, 30);
      loopback(2, 40);
      clr_off[2] = 100;
      clr_off[3] = 255;
      loopback(4, 0);
      clr_off[5] = 17;
      loopback(5, 0);
      run_plan(6, 1'b0, "underrun");
   endtask

   task automatic test_late_overwrite();
      clear_plan();
      n_resp[0] = 1; off_a[0] = 255; val_a[0] = 64;
      n_resp[1] = 2; off_a[1] = 5;   val_a[1] = 10;  off_b[1] = 200; val_b[1] = 20;
      n_resp[2] = 2; off_a[2] = 3;   val_a[2] = 100; off_b[2] = 255; val_b[2] = -50;
      loopback(3, 0);
      run_plan(5, 1'b0, "late_overwrite");
   endtask

   task automatic test_random();
      clear_plan();
      for (int p = 0; p < 10; p++) begin
         n_resp[p] = int'($urandom_range(2, 0));
         off_a[p]  = int'($urandom_range(254, 0));
         off_b[p]  = int'($urandom_range(255, off_a[p] + 1));
         if (n_resp[p] == 1 && $urandom_range(3, 0) == 0) off_a[p] = 255;
         val_a[p]  = int'($urandom_range(255, 0)) - 128;
         val_b[p]  = int'($urandom_range(255, 0)) - 128;
         clr_off[p] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) : -1;
      end
      run_plan(10, 1'b0, "random");
   endtask

   task automatic test_disable();
      int stb_seen, pwm_seen;
      do_reset();
      clear_plan();
      loopback(0, 0);
      loopback(1, 0);
      run_plan(2, 1'b1, "disable_prep");
      for (int c = 0; c < 50; c++) begin
         @(posedge clk_i);
         #1;
      end
      vec_cnt++;
      if (pwm_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL disable_pre: got pwm %b expected 1", pwm_o);
      end
      enable_i = 1'b0;
      m_running = 1'b0;
      stb_seen = 0;
      pwm_seen = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk_i);
         #1;
         stb_seen += int'(next_data_strobe_o !== 1'b0);
         pwm_seen += int'(pwm_o !== 1'b0);
      end
      vec_cnt++;
      if (stb_seen != 0 || pwm_seen != 0) begin
         err_cnt++;
         $display("FAIL disable_quiet: got strobes=%0d pwm=%0d expected 0/0", stb_seen, pwm_seen);
      end
      $display("disable_quiet: strobes=%0d pwm_high=%0d", stb_seen, pwm_seen);
      clear_plan();
      loopback(0, 0);
      loopback(1, 64);
      loopback(2, 0);
      run_plan(3, 1'b1, "reenable");
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      m_duty = 0;
      m_running = 1'b0;
      m_ur = 1'b0;
      test_reset();
      test_normal();
      test_extremes();
      test_underrun();
      test_late_overwrite();
      test_random();
      test_disable();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/pwm_dac.md
# pwm_dac

Sample-consuming output stage for the waveform generators. Once per PWM period it issues a one-cycle next-data request strobe, captures the returned signed sample on the producer's valid strobe, and converts it to a pulse-width-modulated pin output. It sits at the end of the sample chain, driving the producer's `next_data_strobe_i` and consuming its `data_o`/`data_out_valid_strobe_o` pair.

## Interface
- `N_FRAC`, default 7: sample is signed, `N_FRAC+1` bits wide. PWM period is `2^(N_FRAC+1)` clocks.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: asynchronous, active-low reset.
- `enable_i` input 1: run request; level-sensitive.
- `data_i` input `N_FRAC+1`: signed sample from the producer.
- `data_in_valid_strobe_i` input 1: one-cycle qualifier for `data_i`.
- `underrun_clr_i` input 1: clears `underrun_o`.
- `next_data_strobe_o` output 1: one-cycle sample request to the producer.
- `pwm_o` output 1: PWM pin.
- `underrun_o` output 1: sticky flag; set when a RUN period ends without a new sample.

## Operation
- Width W = `N_FRAC+1`. Period counter `cnt` is unsigned W bits and counts 0..2^W−1. A wrap is the cycle where `cnt` = 2^W−1.
- Duty conversion is offset binary: `duty = data_i` with the MSB inverted. For W=8, −128 maps to 0, 0 maps to 128, and 127 maps to 255.
- Registers:
  - `cnt`
  - `pending` (W bits) and `pending_vld`
  - `active` (W bits)
  - `state`
  - `underrun_o`
- State `IDLE`:
  - `cnt`=0, `pending_vld`=0, `active`=0.
  - `pwm_o`=0, and no requests are issued.
  - When `enable_i`=1, go to `PRIME`.
- State `PRIME`:
  - `cnt` runs and requests are issued, but `pwm_o` is held at 0.
  - At wrap with a sample available: load `active` and go to `RUN`.
  - At wrap with no sample: stay in `PRIME`. `underrun_o` is not set.
- State `RUN`:
  - `pwm_o` = (`cnt` < `active`).
  - At wrap with a sample available: load `active`.
  - At wrap with no sample: hold `active` and set `underrun_o`.
- From any non-IDLE state, `enable_i`=0 returns to `IDLE` on the next edge. `underrun_o` is retained.
- Request strobe: `next_data_strobe_o` = (state ≠ `IDLE`) and (`cnt` = 0). It is decoded from registers only, with no input-to-output combinational path.
- Capture: a valid strobe when not at wrap writes `pending` and sets `pending_vld`. A second strobe in the same period overwrites `pending` (last wins, no flag).
- Simultaneous valid strobe and wrap: the incoming `data_i` bypasses straight into `active` and takes precedence over `pending`. `pending_vld` is cleared.
- Any other wrap: if `pending_vld`=1, `active` ← `pending` and `pending_vld` is cleared.
- Valid strobes in `IDLE` are ignored.
- Underrun flag: `underrun_clr_i` clears `underrun_o`. If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values: `pwm_o`=0, `next_data_strobe_o`=0, `underrun_o`=0, state `IDLE`, all counters and registers 0.
- Reset is asynchronous; assertion mid-period forces all outputs low immediately.
- Enable to first request: `enable_i` sampled high at edge k gives `PRIME` with `cnt`=0 after edge k, so `next_data_strobe_o`=1 during that cycle.
- Requests repeat every 2^W cycles.
- Response window: a sample is accepted any cycle up to and including the wrap of the same period. The producer's registered response (1 cycle) fits.
- New duty takes effect at the first `cnt`=0 after the wrap, i.e. one full period after the request that fetched it.
- `pwm_o` is high for exactly `active` cycles per period, starting at `cnt`=0. Duty 0 gives a constant low; 2^W−1 gives low for one cycle.
- `enable_i` low: `pwm_o` is 0 from the next cycle.

## Structure
- Shared package/header holds:
  - state encodings `IDLE`/`PRIME`/`RUN` (2 bits)
  - the offset-binary conversion function
  - the default `N_FRAC` constant, shared with the generators
- One natural sub-module: `period_counter`, a W-bit free-running counter with synchronous clear/hold and a wrap flag, reusable by other rate-strobe users.

## Test plan
- Reset behaviour: assert `rst_i` low mid-RUN between clock edges → all outputs 0 without waiting for an edge. Release, `enable_i`=0 → no strobes for 1000 cycles.
- Normal operation with `N_FRAC`=7 and a loopback producer returning 0 one cycle after each request:
  - first strobe in the cycle after enable is sampled;
  - `pwm_o`=0 for the first 256 cycles;
  - then `pwm_o` high 128 / low 128 repeatedly.
- Duty extremes: response −128 → `pwm_o` constant 0 in RUN. Response 127 → 255 high, 1 low per period.
- Underrun: in RUN, withhold one response → `underrun_o` rises in the cycle after the wrap and the previous duty repeats. Pulse `underrun_clr_i` → flag drops. Assert clear and a new underrun in the same cycle → flag stays 1.
- Late response and overwrite:
  - valid strobe exactly on the wrap cycle with value 64 → next period high for 192 cycles;
  - two strobes (10 then 20) in one period → the duty from 20 (148) is used.
- Disable and re-enable: drop `enable_i` at `cnt`=50 → `pwm_o`=0 and no strobes from the next cycle. Re-enable → a fresh PRIME period (pwm low for 256 cycles) before output resumes.
